alu_serial_responder: RTL and testbench

//  Request/response ALU engine: accepts one operand set (a, b, sel, c_in) per

---
 rtl/alu_serial_responder.sv | 107 ++++++++++
 tb/tb_alu_serial_responder.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/alu_serial_responder.sv
// Bit-serial add/subtract engine behind a valid/ready request/response handshake.
// One full-adder slice processes one bit per clock, LSB first.
module alu_serial_responder #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  input  logic             c_in,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] result,
  output logic             c_out
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             c_out_q, c_out_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             sum_bit;
  logic             carry_nxt;

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    result_d  = result_q;
    carry_d   = carry_q;
    c_out_d   = c_out_q;
    cnt_d     = cnt_q;
    sum_bit   = a_q[0] ^ b_q[0] ^ carry_q;
    carry_nxt = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          // Subtraction is a + ~b + !borrow_in
          a_d     = a;
          b_d     = sel ? ~b : b;
          carry_d = sel ? ~c_in : c_in;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = carry_nxt;
        sum_d   = {sum_bit, sum_q[WIDTH-1:1]};
        cnt_d   = cnt_q + CntW'(1);
        // Publish only on completion so result holds steady outside DONE
        if (cnt_q == CntW'(WIDTH - 1)) begin
          result_d = {sum_bit, sum_q[WIDTH-1:1]};
          c_out_d  = carry_nxt;
          state_d  = StDone;
        end
      end
      StDone: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      c_out_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sum_q    <= sum_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      c_out_q  <= c_out_d;
      cnt_q    <= cnt_d;
    end
  end

  assign req_ready = (state_q == StIdle);
  assign rsp_valid = (state_q == StDone);
  assign result    = result_q;
  assign c_out     = c_out_q;

endmodule

// File: tb/tb_alu_serial_responder.sv
// Directed bench for alu_serial_responder (WIDTH=4): arithmetic, latency,
// backpressure and mid-transaction reset, with hand-computed expectations.
module tb_alu_serial_responder;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sel;
  logic         c_in;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] result;
  logic         c_out;

  int total = 0;
  int fails = 0;

  alu_serial_responder #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .a         (a),
    .b         (b),
    .sel       (sel),
    .c_in      (c_in),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .result    (result),
    .c_out     (c_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full transaction; hold = cycles of rsp_ready=0 in DONE, rdy_early drives
  // rsp_ready high from acceptance onward (must be ignored until DONE).
  task automatic run(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                     input logic tsel, input logic tcin, input logic [W-1:0] exp_res,
                     input logic exp_co, input int hold, input logic rdy_early);
    check({tag, " req_ready idle"}, {7'd0, req_ready}, 8'd1);
    req_valid = 1'b1;
    a = ta;
    b = tb_;
    sel = tsel;
    c_in = tcin;
    tick();  // acceptance edge N
    req_valid = 1'b0;
    a = ~ta;
    b = ~tb_;
    sel = ~tsel;
    c_in = ~tcin;
    rsp_ready = rdy_early;
    check({tag, " req_ready busy"}, {7'd0, req_ready}, 8'd0);
    repeat (W - 1) tick();
    check({tag, " rsp_valid early"}, {7'd0, rsp_valid}, 8'd0);
    tick();
    check({tag, " rsp_valid"}, {7'd0, rsp_valid}, 8'd1);
    check({tag, " result"}, {4'd0, result}, {4'd0, exp_res});
    check({tag, " c_out"}, {7'd0, c_out}, {7'd0, exp_co});
    if (hold > 0) begin
      req_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
        a = 4'(i);
        b = 4'(i + 3);
        tick();
        check({tag, " hold rsp_valid"}, {7'd0, rsp_valid}, 8'd1);
        check({tag, " hold result"}, {4'd0, result}, {4'd0, exp_res});
        check({tag, " hold c_out"}, {7'd0, c_out}, {7'd0, exp_co});
        check({tag, " hold req_ready"}, {7'd0, req_ready}, 8'd0);
      end
      req_valid = 1'b0;
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check({tag, " rsp_valid drop"}, {7'd0, rsp_valid}, 8'd0);
    check({tag, " req_ready back"}, {7'd0, req_ready}, 8'd1);
    check({tag, " result held"}, {4'd0, result}, {4'd0, exp_res});
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    a = '0;
    b = '0;
    sel = 1'b0;
    c_in = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check("reset req_ready", {7'd0, req_ready}, 8'd1);
    check("reset rsp_valid", {7'd0, rsp_valid}, 8'd0);
    check("reset result", {4'd0, result}, 8'd0);
    check("reset c_out", {7'd0, c_out}, 8'd0);

    run("add_wrap", 4'b1111, 4'b0001, 1'b0, 1'b0, 4'b0000, 1'b1, 0, 1'b0);
    run("sub", 4'b1001, 4'b0001, 1'b1, 1'b0, 4'b1000, 1'b1, 0, 1'b1);
    run("sub_bin", 4'b0001, 4'b0001, 1'b1, 1'b1, 4'b1111, 1'b0, 0, 1'b0);
    run("add", 4'b0111, 4'b0011, 1'b0, 1'b0, 4'b1010, 1'b0, 0, 1'b1);
    run("add_cin", 4'b0111, 4'b0011, 1'b0, 1'b1, 4'b1011, 1'b0, 0, 1'b0);
    run("sub_ge", 4'b1100, 4'b0101, 1'b1, 1'b0, 4'b0111, 1'b1, 0, 1'b0);
    run("bp", 4'b0101, 4'b0110, 1'b0, 1'b1, 4'b1100, 1'b0, 10, 1'b0);

    // Abort during the second SHIFT cycle
    req_valid = 1'b1;
    a = 4'b0011;
    b = 4'b0100;
    sel = 1'b0;
    c_in = 1'b0;
    tick();
    req_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort rsp_valid", {7'd0, rsp_valid}, 8'd0);
    check("abort req_ready", {7'd0, req_ready}, 8'd1);
    check("abort result", {4'd0, result}, 8'd0);
    check("abort c_out", {7'd0, c_out}, 8'd0);
    repeat (W + 2) begin
      tick();
      check("abort no rsp", {7'd0, rsp_valid}, 8'd0);
    end
    run("post_abort", 4'b0110, 4'b0111, 1'b1, 1'b0, 4'b1111, 1'b0, 0, 1'b0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
